// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM with per-byte write enables, a registered
// read port with a valid strobe, and a clear engine that fills every word
// with CLR_VAL after reset or on request.
module ram_sync_clr #(
  parameter int                 DATA_W  = 16,
  parameter int                 ADDR_W  = 8,
  parameter int                 DEPTH   = 256,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  ce,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Depth and last clear address in the one-bit-wider pointer domain, so a
  // full 2**ADDR_W array terminates on the compare instead of wrapping.
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_P  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_P   = (ADDR_W + 1)'(1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   clr_ptr_q, clr_ptr_d;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              in_range_p0;
  logic              acc_p0;
  logic              wr_en_p0;
  logic              rd_en_p0;
  logic              clr_wr_p0;
  logic [IDX_W-1:0]  addr_idx_p0;
  logic [IDX_W-1:0]  clr_idx_p0;
  logic [DATA_W-1:0] rd_word_p0;

  logic [DATA_W-1:0] rdata_p1;
  logic              vld_p1;

  // Replace the bytes of old_w selected by be_m with the matching bytes of new_w.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     be_m
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be_m[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // ---- stage 0: request decode ----
  // A clear request in IDLE wins over a simultaneous access; in CLEAR every
  // request input is ignored.
  assign in_range_p0 = ({1'b0, addr} < DEPTH_P);
  assign acc_p0      = (state_q == ST_IDLE) && ce && !clr;
  assign wr_en_p0    = acc_p0 && we && in_range_p0;
  assign rd_en_p0    = acc_p0 && !we;
  assign clr_wr_p0   = (state_q == ST_CLEAR);
  assign addr_idx_p0 = addr[IDX_W-1:0];
  assign clr_idx_p0  = clr_ptr_q[IDX_W-1:0];

  // Out-of-range reads return the clear value rather than aliasing a word.
  assign rd_word_p0  = in_range_p0 ? mem[addr_idx_p0] : CLR_VAL;

  // FSM state and clear pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next-state logic: walk the clear pointer to DEPTH-1, then idle until clr.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_ptr_q == LAST_P) begin
          state_d   = ST_IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + ONE_P;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end
      end
    endcase
  end

  // Memory array: clear-engine fill or byte-masked user write.
  always_ff @(posedge clk) begin
    if (clr_wr_p0) begin
      mem[clr_idx_p0] <= CLR_VAL;
    end else if (wr_en_p0) begin
      mem[addr_idx_p0] <= merge_bytes(mem[addr_idx_p0], wdata, be);
    end
  end

  // ---- stage 1: registered read data and its one-cycle valid strobe ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= rd_en_p0;
      if (rd_en_p0) begin
        rdata_p1 <= rd_word_p0;
      end
    end
  end

  assign rdata  = rdata_p1;
  assign rvalid = vld_p1;
  assign busy   = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_sync_clr.sv
// Randomised and directed bench for ram_sync_clr. Two instances share the
// stimulus: one full 256-word array and one 200-word array in the same
// 8-bit address space, each compared against a word-level reference model.
module tb_ram_sync_clr;

  localparam int          DEP_F = 256;
  localparam int          DEP_P = 200;
  localparam logic [15:0] CV_F  = 16'hA5A5;
  localparam logic [15:0] CV_P  = 16'h5A3C;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        ce;
  logic        we;
  logic [1:0]  be;
  logic [7:0]  addr;
  logic [15:0] wdata;

  logic        busy_f, rvalid_f, busy_p, rvalid_p;
  logic [15:0] rdata_f, rdata_p;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: remaining clear edges, memory image, read register.
  logic [15:0] m_mem    [2][256];
  int          m_left   [2];
  logic [15:0] m_rdata  [2];
  logic        m_rvalid [2];

  ram_sync_clr #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEP_F), .CLR_VAL(CV_F)) u_full (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_f), .ce(ce), .we(we), .be(be),
    .addr(addr), .wdata(wdata), .rdata(rdata_f), .rvalid(rvalid_f)
  );

  ram_sync_clr #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEP_P), .CLR_VAL(CV_P)) u_part (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_p), .ce(ce), .we(we), .be(be),
    .addr(addr), .wdata(wdata), .rdata(rdata_p), .rvalid(rvalid_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int depth_of(input int k);
    return (k == 0) ? DEP_F : DEP_P;
  endfunction

  function automatic logic [15:0] clrval_of(input int k);
    return (k == 0) ? CV_F : CV_P;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_fill(input int k);
    for (int i = 0; i < 256; i++) m_mem[k][i] = clrval_of(k);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k]   = depth_of(k);
      model_fill(k);
      m_rdata[k]  = 16'h0000;
      m_rvalid[k] = 1'b0;
    end
  endtask

  // One rising edge of the reference model, using the inputs as driven.
  task automatic model_step();
    logic [15:0] w;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      m_rvalid[k] = 1'b0;
      if (m_left[k] > 0) begin
        m_left[k]--;
      end else if (clr) begin
        m_left[k] = depth_of(k);
        model_fill(k);
      end else if (ce && we) begin
        if (int'(addr) < depth_of(k)) begin
          w = m_mem[k][addr];
          if (be[0]) w[7:0]  = wdata[7:0];
          if (be[1]) w[15:8] = wdata[15:8];
          m_mem[k][addr] = w;
        end
      end else if (ce) begin
        m_rdata[k]  = (int'(addr) < depth_of(k)) ? m_mem[k][addr] : clrval_of(k);
        m_rvalid[k] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("busy_f",   32'(busy_f),   32'(m_left[0] > 0));
    chk("rvalid_f", 32'(rvalid_f), 32'(m_rvalid[0]));
    chk("rdata_f",  32'(rdata_f),  32'(m_rdata[0]));
    chk("busy_p",   32'(busy_p),   32'(m_left[1] > 0));
    chk("rvalid_p", 32'(rvalid_p), 32'(m_rvalid[1]));
    chk("rdata_p",  32'(rdata_p),  32'(m_rdata[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle_in();
    clr = 1'b0; ce = 1'b0; we = 1'b0; be = 2'b00; addr = 8'h00; wdata = 16'h0000;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
    clr = 1'b0; ce = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    tick();
    idle_in();
  endtask

  task automatic rd(input logic [7:0] a);
    clr = 1'b0; ce = 1'b1; we = 1'b0; addr = a; be = 2'($urandom_range(0, 3));
    tick();
    idle_in();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    idle_in();
    while ((busy_f || busy_p) && n < 2000) begin
      tick();
      n++;
    end
    chk("wait_idle", 32'(busy_f | busy_p), 32'd0);
  endtask

  initial begin
    int cnt;
    int cnt_p;

    idle_in();
    rst = 1'b1;
    model_reset();

    // Post-reset clear
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    cnt_p = 0;
    while (busy_f && cnt < 1000) begin
      if (busy_p) cnt_p++;
      tick();
      cnt++;
    end
    chk("t1_busy_len_full", 32'(cnt), 32'd256);
    chk("t1_busy_len_part", 32'(cnt_p), 32'd200);
    rd(8'd0);
    chk("t1_rd0", 32'(rdata_f), 32'hA5A5);
    chk("t1_rd0_vld", 32'(rvalid_f), 32'd1);
    rd(8'd127);
    chk("t1_rd127", 32'(rdata_f), 32'hA5A5);
    rd(8'd255);
    chk("t1_rd255", 32'(rdata_f), 32'hA5A5);
    chk("t1_rd255_part", 32'(rdata_p), 32'h5A3C);
    chk("t1_rd255_part_vld", 32'(rvalid_p), 32'd1);

    // Write then read, back-to-back reads
    wr(8'h10, 16'h1234, 2'b11);
    chk("t2_wr_novld", 32'(rvalid_f), 32'd0);
    rd(8'h10);
    chk("t2_rd", 32'(rdata_f), 32'h1234);
    chk("t2_rd_vld", 32'(rvalid_f), 32'd1);
    ce = 1'b1; we = 1'b0; addr = 8'h10;
    tick();
    chk("t2_b2b_v0", 32'(rvalid_f), 32'd1);
    addr = 8'h11;
    tick();
    chk("t2_b2b_v1", 32'(rvalid_f), 32'd1);
    chk("t2_b2b_d1", 32'(rdata_f), 32'hA5A5);
    idle_in();
    tick();
    chk("t2_idle_novld", 32'(rvalid_f), 32'd0);
    chk("t2_idle_hold", 32'(rdata_f), 32'hA5A5);

    // Byte enables
    wr(8'h20, 16'hFFFF, 2'b11);
    wr(8'h20, 16'h0000, 2'b01);
    rd(8'h20);
    chk("t3_be01", 32'(rdata_f), 32'hFF00);
    wr(8'h20, 16'h0000, 2'b00);
    rd(8'h20);
    chk("t3_be00", 32'(rdata_f), 32'hFF00);

    // Clear on request, with the colliding write dropped
    wr(8'h05, 16'hBEEF, 2'b11);
    rd(8'h05);
    chk("t4_pre", 32'(rdata_f), 32'hBEEF);
    clr = 1'b1; ce = 1'b1; we = 1'b1; addr = 8'h06; wdata = 16'h1111; be = 2'b11;
    tick();
    chk("t4_busy_start", 32'(busy_f), 32'd1);
    cnt = 0;
    while (busy_f && cnt < 1000) begin
      clr   = ($urandom_range(0, 15) == 0);
      ce    = 1'b1;
      we    = 1'($urandom_range(0, 1));
      be    = 2'($urandom_range(0, 3));
      addr  = 8'($urandom);
      wdata = 16'($urandom);
      tick();
      cnt++;
    end
    chk("t4_busy_len", 32'(cnt), 32'd256);
    wait_idle();
    rd(8'h05);
    chk("t4_rd05", 32'(rdata_f), 32'hA5A5);
    rd(8'h06);
    chk("t4_rd06", 32'(rdata_f), 32'hA5A5);

    // Reset in the middle of a clear
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (100) tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t5_rst_rdata", 32'(rdata_f), 32'd0);
    chk("t5_rst_rvalid", 32'(rvalid_f), 32'd0);
    chk("t5_rst_busy", 32'(busy_f), 32'd1);
    chk("t5_rst_busy_p", 32'(busy_p), 32'd1);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    while (busy_f && cnt < 1000) begin
      tick();
      cnt++;
    end
    chk("t5_busy_len", 32'(cnt), 32'd256);

    // Out-of-range handling in the 200-word instance
    wr(8'd250, 16'h7777, 2'b11);
    rd(8'd250);
    chk("t6_oor_rd_part", 32'(rdata_p), 32'h5A3C);
    chk("t6_oor_vld_part", 32'(rvalid_p), 32'd1);
    chk("t6_inr_rd_full", 32'(rdata_f), 32'h7777);
    rd(8'd50);
    chk("t6_alias_part", 32'(rdata_p), 32'h5A3C);
    wr(8'd199, 16'h4321, 2'b11);
    rd(8'd199);
    chk("t6_last_part", 32'(rdata_p), 32'h4321);

    // Random traffic, including clear requests mixed with accesses
    for (int i = 0; i < 600; i++) begin
      clr   = ($urandom_range(0, 99) == 0);
      ce    = ($urandom_range(0, 3) != 0);
      we    = 1'($urandom_range(0, 1));
      be    = 2'($urandom_range(0, 3));
      addr  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(180, 255))
                                           : 8'($urandom_range(0, 15));
      wdata = 16'($urandom);
      tick();
    end

    // Full read sweep against the model image
    wait_idle();
    for (int a = 0; a < 256; a++) rd(8'(a));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_sync_clr.md
Name: ram_sync_clr

Overview:
Parametrised single-port synchronous RAM. It is the next generation of the team's 256x16 RAM block.
- Separate write and read data buses replace the tristate bus.
- Adds per-byte write enables, a registered read with a valid strobe, and a hardware clear engine.
- The clear engine fills every location with a known value after reset or on request.
- Serves as the general data/program store for the Rechenwerk and later datapath stages.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8
ADDR_W, 8, address width in bits
DEPTH, 256, number of words; 1 <= DEPTH <= 2**ADDR_W
CLR_VAL, 0, DATA_W-bit value written to every word during clear

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset; asynchronous, active-high
clr  in  1  clear request; single-cycle pulse, sampled while idle
busy  out  1  high while the clear engine runs
ce  in  1  chip enable; access request
we  in  1  1 = write, 0 = read; qualified by ce
be  in  DATA_W/8  byte write enables; be[i] covers wdata[8i+7:8i]
addr  in  ADDR_W  word address
wdata  in  DATA_W  write data
rdata  out  DATA_W  registered read data
rvalid  out  1  one-cycle strobe: rdata updated this cycle

Behaviour:
Reset state
- rst high: state=CLEAR, clr_ptr=0, busy=1, rdata=0, rvalid=0.
- Memory contents are not touched asynchronously.

States
- CLEAR
  - Each rising edge writes CLR_VAL to mem[clr_ptr], then clr_ptr increments.
  - The edge that writes clr_ptr==DEPTH-1 moves to IDLE, drops busy to 0 and resets clr_ptr to 0.
  - After rst falls, busy is high for exactly DEPTH rising edges.
- IDLE
  - Accepts accesses.
  - clr=1 moves to CLEAR on the next edge; busy=1 from that edge.
  - The clear takes DEPTH edges, the same as the post-reset clear.

While in CLEAR
- ce, we, be, addr, wdata and clr are ignored.
- No write occurs, rvalid stays 0 and rdata holds its value.
- A clr pulse does not restart the sequence.

Write (IDLE, ce=1, we=1, clr=0)
- On the edge, byte i of mem[addr] takes wdata byte i for each be[i]=1.
- Other bytes are unchanged.
- be all-zero means no change.
- rvalid=0.

Read (IDLE, ce=1, we=0, clr=0)
- On the edge, rdata <= mem[addr] and rvalid=1 for that one cycle (latency 1).
- be is ignored.
- Back-to-back reads every cycle give rvalid high continuously.

Other rules
- No access (ce=0): rvalid=0; rdata holds the last read value.
- clr=1 together with ce=1 in IDLE: clr has priority; the access is dropped (no write, rvalid=0).
- Read-after-write to the same address on the next cycle returns the new data; there is no bypass requirement within one cycle.
- Out-of-range address (addr >= DEPTH): write is ignored; read gives rdata=CLR_VAL with rvalid=1.
- rst asserted mid-clear or mid-access: immediate return to the reset state; the clear restarts from address 0 after rst falls.
- Arithmetic: clr_ptr is ADDR_W+1 bits wide, so DEPTH = 2**ADDR_W does not wrap before the termination compare.

Test Plan:
1. Post-reset clear (DATA_W=16, DEPTH=256, CLR_VAL=16'hA5A5): release rst -> busy high for exactly 256 edges, then 0; reads of addr 0, 127, 255 return 16'hA5A5 with rvalid=1 one cycle after each request.
2. Write/read: write 16'h1234 to addr 8'h10 with be=2'b11, then read 8'h10 -> next cycle rdata=16'h1234, rvalid=1; a back-to-back read of 8'h11 gives rvalid high for two consecutive cycles.
3. Byte enables: addr 8'h20 holds 16'hFFFF; write 16'h0000 with be=2'b01 -> readback 16'hFF00; then write with be=2'b00 -> still 16'hFF00.
4. Clear on request: write 16'hBEEF to 8'h05, pulse clr together with ce=1/we=1 to 8'h06 -> write dropped; busy for 256 edges; accesses during busy ignored (rvalid=0); afterwards 8'h05 and 8'h06 read CLR_VAL.
5. Reset mid-clear: assert rst after 100 clear edges -> rdata=0, rvalid=0, busy=1 immediately; after release, busy lasts a full 256 edges.
6. Out-of-range (ADDR_W=8, DEPTH=200): write 16'h7777 to addr 8'd250 -> no memory change; read 8'd250 -> rdata=CLR_VAL, rvalid=1; addr 8'd199 reads and writes normally.
